serial_adder: RTL

Multi-cycle, parametrised add/subtract unit built around the single-bit full-adder cell. It processes two WIDTH-bit operands DIGIT bits per clock, from LSB to MSB, with the carry held in a flip-flop between digits. It reports sum, carry-out and signed overflow through a start/busy/done handshake. It is the area-reduced replacement for wide combinational ripple adders in datapaths that can tolerate WIDTH/DIGIT cycles of latency.

---
 rtl/serial_adder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands processed DIGIT bits per clock, LSB first.
// Result, carry-out and signed overflow load together at the end of each operation.
//   state  | meaning
//   S_IDLE | waiting for i_start
//   S_RUN  | one digit per clock, N = WIDTH/DIGIT clocks
//   S_DONE | result just loaded; o_done high for this one cycle
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_co,
  output logic             o_ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_load;
  logic             w_last;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [DIGIT+1:0] w_digit;
  logic [DIGIT-1:0] w_dsum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_acc_nxt;

  // Returns {carry into top bit, carry out, DIGIT-bit sum} of a full-adder ripple.
  function automatic logic [DIGIT+1:0] f_digit_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c_in
  );
    logic [DIGIT-1:0] s;
    logic             c;
    logic             c_top;
    s     = '0;
    c     = c_in;
    c_top = c_in;
    for (int i = 0; i < DIGIT; i++) begin
      c_top = c;
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c_top, c, s};
  endfunction

  assign w_digit   = f_digit_add(r_a[DIGIT-1:0], r_b[DIGIT-1:0], r_carry);
  assign w_dsum    = w_digit[DIGIT-1:0];
  assign w_cout    = w_digit[DIGIT];
  assign w_cmsb    = w_digit[DIGIT+1];
  assign w_acc_nxt = WIDTH'({w_dsum, r_acc} >> DIGIT);
  assign w_last    = (r_cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end
      end
      S_RUN: begin
        if (w_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        if (i_start) begin
          w_state_nxt = S_RUN;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign o_busy = (r_state == S_RUN);
  assign o_done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      o_sum   <= '0;
      o_co    <= 1'b0;
      o_ovf   <= 1'b0;
    end else if (w_load) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_acc   <= '0;
      r_carry <= i_sub | i_cin;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_acc   <= w_acc_nxt;
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
      // Final digit: publish the result; outputs change only here.
      if (w_last) begin
        o_sum <= w_acc_nxt;
        o_co  <= w_cout;
        o_ovf <= w_cmsb ^ w_cout;
      end
    end
  end

endmodule
